// File: rtl/hazard_ctrl.sv
// Hazard/flush controller for the 5-stage MIPS core: stalls, bubbles, flushes and forwarding selects.
// Optional saturating stall/flush statistics when HAZARD_STATS_EN is defined.
module hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int BR_PENALTY = 1,
    parameter int STAT_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    input  logic              i_id_uses_rs,
    input  logic              i_id_uses_rt,
    input  logic [REG_AW-1:0] i_id_dest,
    input  logic              i_id_regwrite,
    input  logic              i_id_memread,
    input  logic              i_id_jr,
    input  logic              i_id_jump,
    input  logic              i_ex_br_taken,
    input  logic              i_mem_ready,
    output logic              o_pc_stall,
    output logic              o_ifid_stall,
    output logic              o_ifid_flush,
    output logic              o_idex_bubble,
    output logic              o_pipe_freeze,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b,
    output logic              o_jr_fwd
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0] o_stall_cnt,
    output logic [STAT_W-1:0] o_flush_cnt
`endif
);

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              load;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
    } ex_sb_t;

    // Later stages only need the fields that are still consulted there.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              load;
    } mem_sb_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              wr;
    } wb_sb_t;

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    ex_sb_t  r_ex;
    mem_sb_t r_mem;
    wb_sb_t  r_wb;
    state_t  r_state, w_next_state;
    logic [1:0] r_cnt, w_next_cnt;
    logic w_load_use, w_jr_haz;

    function automatic logic hit(input logic v, input logic [REG_AW-1:0] a,
                                 input logic [REG_AW-1:0] b);
        return v && (a != '0) && (a == b);
    endfunction

    assign w_load_use = (i_id_uses_rs && hit(r_ex.load, r_ex.rd, i_id_rs)) ||
                        (i_id_uses_rt && hit(r_ex.load, r_ex.rd, i_id_rt));
    assign w_jr_haz   = i_id_jr && (hit(r_ex.wr, r_ex.rd, i_id_rs) ||
                                    hit(r_mem.load, r_mem.rd, i_id_rs));
    assign o_jr_fwd   = i_id_jr && !r_mem.load && hit(r_mem.wr, r_mem.rd, i_id_rs) && !w_jr_haz;

    assign o_fwd_a = hit(r_mem.wr, r_mem.rd, r_ex.rs) ? 2'b10 :
                     hit(r_wb.wr,  r_wb.rd,  r_ex.rs) ? 2'b01 : 2'b00;
    assign o_fwd_b = hit(r_mem.wr, r_mem.rd, r_ex.rt) ? 2'b10 :
                     hit(r_wb.wr,  r_wb.rd,  r_ex.rt) ? 2'b01 : 2'b00;

    always_comb begin
        o_pc_stall    = 1'b0;
        o_ifid_stall  = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_bubble = 1'b0;
        o_pipe_freeze = 1'b0;
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        if (!i_reset_n) begin
            w_next_state = RUN;
        end else if (!i_mem_ready) begin
            o_pipe_freeze = 1'b1;
            o_pc_stall    = 1'b1;
            o_ifid_stall  = 1'b1;
        end else if (r_state == FLUSH && r_cnt != 2'd0) begin
            o_ifid_flush  = 1'b1;
            o_idex_bubble = 1'b1;
            w_next_cnt    = r_cnt - 2'd1;
        end else if (i_ex_br_taken) begin
            o_ifid_flush  = 1'b1;
            o_idex_bubble = 1'b1;
            w_next_state  = FLUSH;
            w_next_cnt    = 2'(BR_PENALTY - 1);
        end else if (w_load_use || w_jr_haz) begin
            // STALL re-enters here each cycle, so a hazard that persists keeps stalling.
            o_pc_stall    = 1'b1;
            o_ifid_stall  = 1'b1;
            o_idex_bubble = 1'b1;
            w_next_state  = STALL;
        end else begin
            o_ifid_flush  = i_id_jump;
            w_next_state  = RUN;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= RUN;
            r_cnt   <= 2'd0;
            r_ex    <= '0;
            r_mem   <= '0;
            r_wb    <= '0;
        end else if (i_mem_ready) begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (o_idex_bubble) begin
                r_ex <= '0;
            end else begin
                r_ex <= '{rd: i_id_dest, wr: i_id_regwrite, load: i_id_memread,
                          rs: i_id_rs, rt: i_id_rt};
            end
            r_mem <= '{rd: r_ex.rd, wr: r_ex.wr, load: r_ex.load};
            r_wb  <= '{rd: r_mem.rd, wr: r_mem.wr};
        end
    end

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] r_stall_cnt, r_flush_cnt;

    // A bubble without a flush can only come from a hazard stall.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (o_idex_bubble && !o_ifid_flush && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (o_ifid_flush && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, reset-in-stall sequence, random run against a pipeline model.
module tb_hazard_ctrl;
    localparam int BRP = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;
    logic       id_uses_rs = 0, id_uses_rt = 0, id_regwrite = 0, id_memread = 0;
    logic       id_jr = 0, id_jump = 0, ex_br_taken = 0, mem_ready = 1;
    logic       pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, jr_fwd;
    logic [1:0] fwd_a, fwd_b;

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.REG_AW(5), .BR_PENALTY(BRP), .STAT_W(16)) dut (
        .i_clk(clk), .i_reset_n(reset_n),
        .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_uses_rs(id_uses_rs), .i_id_uses_rt(id_uses_rt),
        .i_id_dest(id_dest), .i_id_regwrite(id_regwrite), .i_id_memread(id_memread),
        .i_id_jr(id_jr), .i_id_jump(id_jump), .i_ex_br_taken(ex_br_taken),
        .i_mem_ready(mem_ready),
        .o_pc_stall(pc_stall), .o_ifid_stall(ifid_stall), .o_ifid_flush(ifid_flush),
        .o_idex_bubble(idex_bubble), .o_pipe_freeze(pipe_freeze),
        .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_jr_fwd(jr_fwd)
    );

    always #5 clk = ~clk;

    // Packed view: {pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, fwd_a, fwd_b, jr_fwd}
    localparam logic [9:0] E0  = 10'b00000_00_00_0;
    localparam logic [9:0] STL = 10'b11010_00_00_0;
    localparam logic [9:0] FLS = 10'b00110_00_00_0;
    localparam logic [9:0] JFL = 10'b00100_00_00_0;
    localparam logic [9:0] FRZ = 10'b11001_00_00_0;

    typedef struct {
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [4:0] dst;
        logic       rw, mr, jr, jmp, br, rdy;
        logic [9:0] exp;
    } vec_t;
    vec_t vecs[$];

    typedef struct {
        int rd; bit wr; bit ld; int rs; int rt;
    } ins_t;
    ins_t m_ex, m_mem, m_wb;
    int   m_flush_left;

    function automatic logic [9:0] outs();
        return {pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, fwd_a, fwd_b, jr_fwd};
    endfunction

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic drive(input vec_t v);
        id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
        id_dest = v.dst; id_regwrite = v.rw; id_memread = v.mr;
        id_jr = v.jr; id_jump = v.jmp; ex_br_taken = v.br; mem_ready = v.rdy;
    endtask

    task automatic add(input int rs, input int rt, input bit urs, input bit urt, input int dst,
                       input bit rw, input bit mr, input bit jr, input bit jmp, input bit br,
                       input bit rdy, input logic [9:0] exp);
        vec_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.urs = urs; v.urt = urt; v.dst = 5'(dst);
        v.rw = rw; v.mr = mr; v.jr = jr; v.jmp = jmp; v.br = br; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        vec_t z;
        z = '{default: 0};
        z.rdy = 1;
        drive(z);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    function automatic int fsel(int src);
        if (src != 0 && m_mem.wr && m_mem.rd == src) return 2;
        if (src != 0 && m_wb.wr && m_wb.rd == src) return 1;
        return 0;
    endfunction

    function automatic int pick_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 31 : r;
    endfunction

    initial begin
        vec_t v;
        logic [9:0] want;
        ins_t id_i;
        bit lu, jh, jf, bub;
        int fa, fb;

        // lw $2 then dependent add: one stall, then WB forwarding
        add(1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 1, E0);
        add(2, 4, 1, 1, 3, 1, 0, 0, 0, 0, 1, STL);
        add(2, 4, 1, 1, 3, 1, 0, 0, 0, 0, 1, E0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10'b00000_01_00_0);
        // $6 then $5 then consumer of both: MEM beats WB per operand
        add(0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 1, E0);
        add(0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 1, E0);
        add(5, 6, 1, 1, 7, 1, 0, 0, 0, 0, 1, E0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10'b00000_10_01_0);
        // write to $0 in MEM must not forward to an rs=$0 consumer
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, E0);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, E0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E0);
        // lw $31 then jr $31: two stalls, no jr forwarding
        add(0, 0, 0, 0, 31, 1, 1, 0, 0, 0, 1, E0);
        add(31, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, STL);
        add(31, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, STL);
        add(31, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, E0);
        // add $31 then jr $31: one stall, then jr_fwd
        add(0, 0, 0, 0, 31, 1, 0, 0, 0, 0, 1, E0);
        add(31, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, STL);
        add(31, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 10'b00000_00_00_1);
        // branch coincident with load-use: flush wins, two flush cycles
        add(0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 1, 10'b00000_01_00_0);
        add(2, 0, 1, 0, 3, 1, 0, 0, 0, 1, 1, FLS);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FLS);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E0);
        // jump alone
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, JFL);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E0);
        // freeze for 3 cycles in the middle of a branch flush
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, FLS);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FRZ);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FRZ);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FRZ);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FLS);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E0);

        do_reset();
        @(negedge clk);
        check("reset_state", outs(), E0);
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
            @(posedge clk); #1;
        end

        // reset pulled mid-stall clears outputs without waiting for a clock edge
        add(0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 1, E0);
        drive(vecs[vecs.size()-1]);
        @(posedge clk); #1;
        add(9, 0, 1, 0, 4, 1, 0, 0, 0, 0, 1, STL);
        drive(vecs[vecs.size()-1]);
        @(negedge clk);
        check("stall_before_reset", outs(), STL);
        #2 reset_n = 1'b0;
        #1 check("async_reset_mid_stall", outs(), E0);
        @(posedge clk); #1;
        check("held_in_reset", outs(), E0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 check("after_reset_release", outs(), E0);
        @(posedge clk); #1;

        // randomized run against the pipeline model
        do_reset();
        m_ex = '{default: 0}; m_mem = '{default: 0}; m_wb = '{default: 0};
        m_flush_left = 0;
        for (int c = 0; c < 3000; c++) begin
            v.rs = 5'(pick_reg()); v.rt = 5'(pick_reg()); v.dst = 5'(pick_reg());
            v.urs = 1'($urandom_range(0, 1)); v.urt = 1'($urandom_range(0, 1));
            v.rw = 1'($urandom_range(0, 1)); v.mr = ($urandom_range(0, 2) == 0);
            v.jr = ($urandom_range(0, 4) == 0); v.jmp = ($urandom_range(0, 7) == 0);
            v.br = ($urandom_range(0, 7) == 0); v.rdy = ($urandom_range(0, 7) != 0);
            drive(v);
            @(negedge clk);

            lu = m_ex.ld && m_ex.rd != 0 &&
                 ((v.urs && m_ex.rd == int'(v.rs)) || (v.urt && m_ex.rd == int'(v.rt)));
            jh = v.jr && v.rs != 0 &&
                 ((m_ex.wr && m_ex.rd == int'(v.rs)) || (m_mem.ld && m_mem.rd == int'(v.rs)));
            jf = v.jr && v.rs != 0 && m_mem.wr && !m_mem.ld && m_mem.rd == int'(v.rs) && !jh;
            fa = fsel(int'(v.rs) * 0 + m_ex.rs);
            fb = fsel(m_ex.rt);
            bub = 0;
            if (!v.rdy) want = FRZ;
            else if (m_flush_left > 0 || v.br) begin want = FLS; bub = 1; end
            else if (lu || jh) begin want = STL; bub = 1; end
            else if (v.jmp) want = JFL;
            else want = E0;
            want[4:3] = 2'(fa); want[2:1] = 2'(fb); want[0] = jf;
            check($sformatf("rand%0d", c), outs(), want);

            if (v.rdy) begin
                if (m_flush_left > 0) m_flush_left--;
                else if (v.br) m_flush_left = BRP - 1;
                id_i = '{rd: int'(v.dst), wr: v.rw, ld: v.mr, rs: int'(v.rs), rt: int'(v.rt)};
                m_wb = m_mem;
                m_mem = m_ex;
                m_ex = bub ? '{default: 0} : id_i;
            end
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and flush controller for the 5-stage MIPS core.
- Sits beside control: takes ID-stage decode outputs plus EX/MEM status, and drives pipeline-register stall, bubble and flush enables.
- Drives EX operand forwarding selects and the jr forwarding select.
- Keeps its own shadow scoreboard of in-flight destination registers, carried through EX, MEM and WB.

Parameters:
REG_AW, 5, register address width
BR_PENALTY, 1, flush cycles after a taken branch resolved in EX (1..3)
STAT_W, 16, width of statistic counters (optional feature only)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
id_rs  in  REG_AW  ID source register rs
id_rt  in  REG_AW  ID source register rt
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_dest  in  REG_AW  ID destination (already RegDst-muxed)
id_regwrite  in  1  ID RegWrite
id_memread  in  1  ID MemRead (lw)
id_jr  in  1  ID is jr (Jump==01 or 10)
id_jump  in  1  ID is j/jal
ex_br_taken  in  1  branch in EX resolved taken
mem_ready  in  1  data memory ready; 0 freezes pipeline
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID
ifid_flush  out  1  zero IF/ID
idex_bubble  out  1  insert NOP into ID/EX
pipe_freeze  out  1  hold all pipeline registers
fwd_a  out  2  EX operand A select: 00 regfile, 10 MEM result, 01 WB result
fwd_b  out  2  EX operand B select, same encoding
jr_fwd  out  1  jr target taken from MEM-stage result

Behaviour:
- Reset: all outputs 0, scoreboard cleared (all write flags 0), FSM = RUN, counters 0.
- Scoreboard: ex/mem/wb {rd, wr, load, rs, rt}.
  - Per non-frozen edge: ex <= (idex_bubble ? cleared : ID fields); mem <= ex; wb <= mem.
  - Register 0 never counts as a match.
- Forwarding (combinational, on EX entry): fwd_a = 10 if mem_wr && mem_rd==ex_rs; else 01 if wb_wr && wb_rd==ex_rs; else 00. MEM takes priority. fwd_b is the same using ex_rt.
- Load-use hazard: ex_load && ex_rd matches a used ID source.
- jr hazard: id_jr && ((ex_wr && ex_rd==id_rs) || (mem_load && mem_rd==id_rs)).
- jr_fwd = id_jr && mem_wr && !mem_load && mem_rd==id_rs && no jr hazard.
- FSM states: RUN, STALL, FLUSH.
  - RUN: ex_br_taken -> FLUSH with cnt=BR_PENALTY-1; ifid_flush=1, idex_bubble=1 this cycle.
  - RUN, else on load-use or jr hazard: pc_stall=ifid_stall=idex_bubble=1 for one cycle; go to STALL.
  - RUN, else on id_jump: ifid_flush=1 for one cycle; stay in RUN.
  - STALL: re-evaluate hazards against the updated scoreboard. If a hazard remains, keep stalling (jr after lw stalls 2 cycles total); otherwise return to RUN. ex_br_taken in STALL overrides: go to FLUSH.
  - FLUSH: ifid_flush=idex_bubble=1 while cnt>0, decrement each cycle; at cnt==0 return to RUN.
- Priority: freeze > branch flush > stall > jump flush.
- Freeze: mem_ready==0 forces pipe_freeze=pc_stall=ifid_stall=1 and clears flush and bubble. FSM state, cnt and scoreboard hold. Behaviour resumes unchanged on the cycle mem_ready returns to 1.
- Reset asserted mid-stall or mid-flush returns immediately to the reset values.

Optional Feature:
HAZARD_STATS_EN
- Defined: adds outputs stall_cnt and flush_cnt, each STAT_W wide and saturating.
  - stall_cnt increments each cycle idex_bubble=1 due to a stall.
  - flush_cnt increments each cycle ifid_flush=1.
  - Neither counts during freeze; both cleared by reset.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- lw $2 in EX, ID add $3,$2,$4 -> exactly 1 cycle of pc_stall/ifid_stall/idex_bubble. Next cycle fwd_a=10 is wrong; the required response is fwd_a=01 (WB) when the add reaches EX.
- add $5 in MEM, add $6 in WB, EX instruction uses rs=$5, rt=$6 -> fwd_a=10, fwd_b=01. Repeat with rs=$0 -> fwd_a=00.
- lw $31 in EX, ID jr $31 -> 2 stall cycles, then jr_fwd=0 (value now from WB path).
- add $31 in EX, ID jr $31 -> 1 stall, then jr_fwd=1.
- ex_br_taken=1 with BR_PENALTY=2 -> ifid_flush=idex_bubble=1 for 2 consecutive cycles, then RUN.
- ex_br_taken coincident with a load-use hazard -> flush only, no stall. id_jump alone -> ifid_flush for 1 cycle.
- mem_ready=0 for 3 cycles during a FLUSH with cnt=1 -> pipe_freeze held and flush outputs 0 for 3 cycles; after release, 1 flush cycle remains.
- reset_n low mid-STALL -> outputs 0 asynchronously.
